infer_seq_ctrl: RTL and testbench
=================================

// Module: infer_seq_ctrl
// PURPOSE
//  Top-level inference sequencer for the MNIST pipeline: fc1 -> fc2 -> argmax.
//  Accepts one inference request per image, start-pulses each layer engine in order, waits for its done.
//  Supplies per-layer shift_right from software-writable config registers; bounds each layer with a watchdog.
//  Returns the predicted class, or an error flag, on a valid/ready result port.
// PARAMETERS
//  SHIFT_FC1_DEF  7      reset value of fc1 shift register (0..63)
//  SHIFT_FC2_DEF  7      reset value of fc2 shift register (0..63)
//  WDOG_CYCLES    65536  max cycles waiting on any one layer done; >=2
//  CLS_W          4      width of class index (10 classes)
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  req_valid  in   1      inference request (x_mem already loaded)
//  req_ready  out  1      1 only in IDLE
//  cfg_we     in   1      config write strobe
//  cfg_sel    in   1      0=fc1 shift, 1=fc2 shift
//  cfg_shift  in   6      shift value to write
//  fc1_start  out  1      1-cycle start pulse to fc1 engine
//  fc1_done   in   1      fc1 completion pulse
//  fc1_shift  out  6      fc1 shift_right
//  fc2_start  out  1      1-cycle start pulse to fc2 engine
//  fc2_done   in   1      fc2 completion pulse
//  fc2_shift  out  6      fc2 shift_right
//  am_start   out  1      1-cycle start pulse to argmax unit
//  am_done    in   1      argmax completion pulse
//  am_class   in   CLS_W  argmax result, valid while am_done=1
//  res_valid  out  1      result available; held until accepted
//  res_ready  in   1      result consumer ready
//  res_class  out  CLS_W  predicted class (0 on error)
//  res_err    out  1      1 = a layer watchdog expired
//  busy       out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all start pulses, res_valid, res_err, busy = 0; res_class=0;
//    req_ready=1; fc1_shift=SHIFT_FC1_DEF; fc2_shift=SHIFT_FC2_DEF; watchdog=0. Mid-run reset aborts; no result.
//  FSM: IDLE -> F1_GO -> F1_WAIT -> F2_GO -> F2_WAIT -> AM_GO -> AM_WAIT -> RESULT -> IDLE.
//  IDLE: req_valid at edge N -> F1_GO; fc1_start=1 during cycle N+1 only. Each *_GO lasts exactly 1 cycle.
//  *_WAIT: watchdog cleared on entry, +1 per cycle; matching done -> next *_GO (AM_WAIT: capture am_class).
//  Watchdog: done not seen by wait cycle WDOG_CYCLES -> RESULT with res_err=1, res_class=0.
//    Done and expiry in the same cycle: done wins.
//  RESULT: res_valid=1, res_class/res_err stable until res_ready=1; transfer edge -> IDLE; earliest next accept is 1 cycle later.
//  done inputs outside their own *_WAIT state (incl. IDLE, *_GO, other layer's wait) are ignored.
//  Config: cfg_we honoured only in IDLE; writes while busy are dropped. cfg_we with an accepted request in the
//    same cycle: write applies, and the new value is used by that inference. Shift outputs are stable while busy.
//  Arithmetic: watchdog counter is $clog2(WDOG_CYCLES)+1 bits, saturating; no wrap.
// CONFIGURATION
//  INFER_PERF_CNT_EN defined: adds output perf_cycles[31:0], the cycles from request accept to the res_valid rise.
//    Latched at RESULT entry; holds until the next accept; reset 0; saturates at 2^32-1.
//  Not defined: no perf_cycles port and no counter logic; all other behaviour identical.
// TESTING
//  Normal run: req at cycle 0, fc1_done after 25k cycles, fc2_done after 340 cycles, am_done with class 7 after 10 cycles
//    -> start pulses exactly 1 cycle each, in order; res_class=7, res_err=0.
//  Backpressure: res_ready=0 for 20 cycles -> res_valid and res_class held; req_ready=0 until the transfer edge.
//  Watchdog: WDOG_CYCLES=100, fc2_done never asserted -> res_err=1, res_class=0; am_start never pulses.
//  Config: write fc1 shift=9 in IDLE -> fc1_shift=9; write fc2 shift=3 while busy -> dropped, fc2_shift unchanged.
//  Spurious/race: fc2_done during F1_WAIT ignored; done coinciding with watchdog expiry -> normal progression.
//  Reset: rst_n low mid-F2_WAIT -> outputs at reset values immediately; a new request then runs cleanly.

Source files
------------

// File: rtl/infer_seq_ctrl_if.sv
// infer_seq_ctrl_if: request/result handshake between a host and the inference sequencer
//   req_valid/req_ready : host asks for one inference (x_mem already loaded)
//   res_valid/res_ready : result transfer; res_class is the predicted class, res_err flags a watchdog expiry
//   modport master : host side (drives req_valid, res_ready)
//   modport slave  : sequencer side (drives req_ready, res_valid, res_class, res_err)
interface infer_seq_ctrl_if #(
    parameter int CLS_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic             res_valid;
    logic             res_ready;
    logic             res_err;
    logic [CLS_W-1:0] res_class;

    modport master (
        output req_valid, res_ready,
        input  req_ready, res_valid, res_class, res_err
    );

    modport slave (
        input  req_valid, res_ready,
        output req_ready, res_valid, res_class, res_err
    );
endinterface

// File: rtl/infer_seq_ctrl.sv
// infer_seq_ctrl: MNIST inference sequencer, runs fc1 -> fc2 -> argmax and returns the class
//   clk, rst_n              : clock (rising edge), asynchronous active-low reset
//   host                    : request/result handshake (infer_seq_ctrl_if.slave)
//   cfg_we/cfg_sel/cfg_shift: shift-register write port, honoured only while idle (sel 0=fc1, 1=fc2)
//   fcN_start/fcN_done      : per-layer 1-cycle start pulse and completion pulse
//   fc1_shift, fc2_shift    : per-layer shift_right, stable while busy
//   am_start/am_done/am_class: argmax start, completion and result (valid with am_done)
//   busy                    : high whenever not idle
//   perf_cycles             : only with INFER_PERF_CNT_EN defined; cycles from accept to res_valid rise
// Optional feature macro: INFER_PERF_CNT_EN
module infer_seq_ctrl #(
    parameter int SHIFT_FC1_DEF = 7,
    parameter int SHIFT_FC2_DEF = 7,
    parameter int WDOG_CYCLES   = 65536,
    parameter int CLS_W         = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    infer_seq_ctrl_if.slave  host,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [5:0]       cfg_shift,
    output logic             fc1_start,
    input  logic             fc1_done,
    output logic [5:0]       fc1_shift,
    output logic             fc2_start,
    input  logic             fc2_done,
    output logic [5:0]       fc2_shift,
    output logic             am_start,
    input  logic             am_done,
    input  logic [CLS_W-1:0] am_class,
    output logic             busy
`ifdef INFER_PERF_CNT_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);
    localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
    // The first wait cycle sees wd=0, so wd=WDOG_CYCLES-1 marks the last allowed cycle.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, F1_GO, F1_WAIT, F2_GO, F2_WAIT, AM_GO, AM_WAIT, RESULT
    } state_t;

    state_t           state, state_nx;
    logic [WD_W-1:0]  wd;
    logic [5:0]       shift1, shift2;
    logic [CLS_W-1:0] cls;
    logic             err;
    logic             waiting, done, expired, accept;

    always_comb begin
        waiting  = (state == F1_WAIT) || (state == F2_WAIT) || (state == AM_WAIT);
        // Only the done belonging to the current wait state counts; all others are ignored.
        done     = (state == F1_WAIT && fc1_done) || (state == F2_WAIT && fc2_done) ||
                   (state == AM_WAIT && am_done);
        expired  = waiting && (wd >= WD_LAST);
        accept   = (state == IDLE) && host.req_valid;
        state_nx = state;
        case (state)
            IDLE:    state_nx = host.req_valid ? F1_GO : IDLE;
            F1_GO:   state_nx = F1_WAIT;
            F1_WAIT: state_nx = done ? F2_GO : (expired ? RESULT : F1_WAIT);
            F2_GO:   state_nx = F2_WAIT;
            F2_WAIT: state_nx = done ? AM_GO : (expired ? RESULT : F2_WAIT);
            AM_GO:   state_nx = AM_WAIT;
            AM_WAIT: state_nx = (done || expired) ? RESULT : AM_WAIT;
            RESULT:  state_nx = host.res_ready ? IDLE : RESULT;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        fc1_start      = (state == F1_GO);
        fc2_start      = (state == F2_GO);
        am_start       = (state == AM_GO);
        host.req_ready = (state == IDLE);
        host.res_valid = (state == RESULT);
        host.res_class = cls;
        host.res_err   = err;
        busy           = (state != IDLE);
        fc1_shift      = shift1;
        fc2_shift      = shift2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            wd     <= '0;
            shift1 <= 6'(SHIFT_FC1_DEF);
            shift2 <= 6'(SHIFT_FC2_DEF);
            cls    <= '0;
            err    <= 1'b0;
        end else begin
            state <= state_nx;
            wd    <= !waiting ? '0 : (wd == '1 ? wd : wd + 1'b1);
            if (state == IDLE && cfg_we && cfg_sel)
                shift2 <= cfg_shift;
            if (state == IDLE && cfg_we && !cfg_sel)
                shift1 <= cfg_shift;
            if (state == AM_WAIT && done) begin
                cls <= am_class;
                err <= 1'b0;
            end else if (expired && !done) begin
                cls <= '0;
                err <= 1'b1;
            end else if (state == RESULT && host.res_ready) begin
                cls <= '0;
                err <= 1'b0;
            end
        end
    end

`ifdef INFER_PERF_CNT_EN
    logic [31:0] run_cnt;

    // run_cnt counts edges since accept; the RESULT-entry edge itself adds the final +1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt     <= '0;
            perf_cycles <= '0;
        end else begin
            run_cnt <= accept ? '0 : (run_cnt == '1 ? run_cnt : run_cnt + 1'b1);
            if (state != RESULT && state_nx == RESULT)
                perf_cycles <= (run_cnt == '1) ? run_cnt : run_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_infer_seq_ctrl.sv
// tb_infer_seq_ctrl: directed self-checking bench for infer_seq_ctrl (watchdog set to 100 cycles)
module tb_infer_seq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [5:0] cfg_shift = '0;
    logic       fc1_start, fc2_start, am_start, busy;
    logic       fc1_done = 1'b0, fc2_done = 1'b0, am_done = 1'b0;
    logic [5:0] fc1_shift, fc2_shift;
    logic [3:0] am_class = '0;
    int         errors = 0, checks = 0;
    int         n1 = 0, n2 = 0, n3 = 0;

    infer_seq_ctrl_if #(.CLS_W(4)) h ();

    infer_seq_ctrl #(.WDOG_CYCLES(100)) dut (
        .clk(clk), .rst_n(rst_n), .host(h),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_shift(cfg_shift),
        .fc1_start(fc1_start), .fc1_done(fc1_done), .fc1_shift(fc1_shift),
        .fc2_start(fc2_start), .fc2_done(fc2_done), .fc2_shift(fc2_shift),
        .am_start(am_start), .am_done(am_done), .am_class(am_class),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Count cycles in which each start is high (sampled before the edge updates state).
    always @(posedge clk) begin
        n1 <= n1 + int'(fc1_start);
        n2 <= n2 + int'(fc2_start);
        n3 <= n3 + int'(am_start);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic accept();
        h.req_valid = 1'b1;
        tick();
        h.req_valid = 1'b0;
    endtask

    // Entered in the layer's GO cycle; returns in the cycle after the done edge.
    task automatic run_layer(input int layer, input int d, input logic [3:0] cls);
        logic [2:0] exp;
        exp = 3'b100 >> (layer - 1);
        checks++;
        if ({fc1_start, fc2_start, am_start} !== exp) begin
            errors++;
            $display("FAIL start_l%0d: got %b want %b", layer, {fc1_start, fc2_start, am_start}, exp);
        end
        tick();
        repeat (d - 1) tick();
        if (layer == 1) fc1_done = 1'b1;
        else if (layer == 2) fc2_done = 1'b1;
        else begin
            am_done  = 1'b1;
            am_class = cls;
        end
        tick();
        fc1_done = 1'b0;
        fc2_done = 1'b0;
        am_done  = 1'b0;
        am_class = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({h.req_ready, busy, h.res_valid, h.res_err, h.res_class, fc1_start, fc2_start, am_start} !== 11'b100_0000_0000) begin
            errors++;
            $display("FAIL reset_ctrl: got rdy=%b busy=%b vld=%b err=%b cls=%0d starts=%b",
                     h.req_ready, busy, h.res_valid, h.res_err, h.res_class, {fc1_start, fc2_start, am_start});
        end
        checks++;
        if (fc1_shift !== 6'd7 || fc2_shift !== 6'd7) begin
            errors++;
            $display("FAIL reset_shift: got %0d/%0d want 7/7", fc1_shift, fc2_shift);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_normal();
        int b1, b2, b3;
        b1 = n1; b2 = n2; b3 = n3;
        accept();
        run_layer(1, 90, 0);
        run_layer(2, 34, 0);
        run_layer(3, 10, 7);
        checks++;
        if ({h.res_valid, h.res_err, h.res_class, h.req_ready, busy} !== 8'b1_0_0111_0_1) begin
            errors++;
            $display("FAIL normal_result: got vld=%b err=%b cls=%0d rdy=%b busy=%b want 1 0 7 0 1",
                     h.res_valid, h.res_err, h.res_class, h.req_ready, busy);
        end
        tick();
        checks++;
        if ({h.res_valid, h.req_ready, busy} !== 3'b010) begin
            errors++;
            $display("FAIL normal_idle: got vld=%b rdy=%b busy=%b want 0 1 0", h.res_valid, h.req_ready, busy);
        end
        checks++;
        if (n1 - b1 != 1 || n2 - b2 != 1 || n3 - b3 != 1) begin
            errors++;
            $display("FAIL normal_pulses: got %0d %0d %0d want 1 1 1", n1 - b1, n2 - b2, n3 - b3);
        end
    endtask

    task automatic test_config();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_shift = 6'd9;
        tick();
        cfg_we = 1'b0;
        checks++;
        if (fc1_shift !== 6'd9 || fc2_shift !== 6'd7) begin
            errors++;
            $display("FAIL cfg_idle: got %0d/%0d want 9/7", fc1_shift, fc2_shift);
        end
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_shift = 6'd12;
        accept();
        cfg_we = 1'b0;
        checks++;
        if (fc2_shift !== 6'd12 || fc1_start !== 1'b1) begin
            errors++;
            $display("FAIL cfg_with_req: got shift=%0d start=%b want 12 1", fc2_shift, fc1_start);
        end
        cfg_we = 1'b1; cfg_sel = 1'b1; cfg_shift = 6'd3;
        tick();
        cfg_we = 1'b0;
        fc1_done = 1'b1;
        tick();
        fc1_done = 1'b0;
        run_layer(2, 2, 0);
        run_layer(3, 2, 8);
        checks++;
        if (fc2_shift !== 6'd12 || fc1_shift !== 6'd9 || h.res_class !== 4'd8) begin
            errors++;
            $display("FAIL cfg_busy_drop: got %0d/%0d cls=%0d want 9/12 cls=8", fc1_shift, fc2_shift, h.res_class);
        end
        tick();
    endtask

    task automatic test_backpressure();
        h.res_ready = 1'b0;
        accept();
        run_layer(1, 3, 0);
        run_layer(2, 4, 0);
        run_layer(3, 2, 5);
        h.req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if ({h.res_valid, h.res_class, h.req_ready} !== 6'b1_0101_0) begin
                errors++;
                $display("FAIL bp_hold%0d: got vld=%b cls=%0d rdy=%b want 1 5 0", i, h.res_valid, h.res_class, h.req_ready);
            end
            tick();
        end
        h.res_ready = 1'b1;
        tick();
        checks++;
        if ({h.res_valid, h.req_ready, fc1_start} !== 3'b010) begin
            errors++;
            $display("FAIL bp_release: got vld=%b rdy=%b start=%b want 0 1 0", h.res_valid, h.req_ready, fc1_start);
        end
        tick();
        h.req_valid = 1'b0;
        run_layer(1, 2, 0);
        run_layer(2, 2, 0);
        run_layer(3, 2, 9);
        checks++;
        if (h.res_class !== 4'd9 || h.res_valid !== 1'b1) begin
            errors++;
            $display("FAIL back_to_back: got cls=%0d vld=%b want 9 1", h.res_class, h.res_valid);
        end
        tick();
    endtask

    task automatic test_spurious();
        fc1_done = 1'b1;
        tick();
        fc1_done = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL spur_idle: got busy=%b want 0", busy);
        end
        accept();
        tick();
        fc2_done = 1'b1; am_done = 1'b1; am_class = 4'd6;
        tick();
        tick();
        fc2_done = 1'b0; am_done = 1'b0; am_class = '0;
        checks++;
        if ({fc2_start, am_start, h.res_valid, busy} !== 4'b0001) begin
            errors++;
            $display("FAIL spur_f1wait: got %b want 0001", {fc2_start, am_start, h.res_valid, busy});
        end
        fc1_done = 1'b1;
        tick();
        fc1_done = 1'b0;
        run_layer(2, 3, 0);
        run_layer(3, 3, 1);
        checks++;
        if (h.res_class !== 4'd1 || h.res_err !== 1'b0) begin
            errors++;
            $display("FAIL spur_result: got cls=%0d err=%b want 1 0", h.res_class, h.res_err);
        end
        tick();
    endtask

    task automatic test_watchdog();
        int b3;
        b3 = n3;
        accept();
        run_layer(1, 5, 0);
        tick();
        repeat (99) tick();
        checks++;
        if (h.res_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL wd_early: got vld=%b busy=%b want 0 1", h.res_valid, busy);
        end
        tick();
        checks++;
        if ({h.res_valid, h.res_err, h.res_class} !== 6'b1_1_0000) begin
            errors++;
            $display("FAIL wd_result: got vld=%b err=%b cls=%0d want 1 1 0", h.res_valid, h.res_err, h.res_class);
        end
        checks++;
        if (n3 != b3) begin
            errors++;
            $display("FAIL wd_no_am: got %0d am pulses want 0", n3 - b3);
        end
        tick();
    endtask

    task automatic test_race();
        accept();
        run_layer(1, 100, 0);
        run_layer(2, 100, 0);
        run_layer(3, 100, 3);
        checks++;
        if ({h.res_valid, h.res_err, h.res_class} !== 6'b1_0_0011) begin
            errors++;
            $display("FAIL race_result: got vld=%b err=%b cls=%0d want 1 0 3", h.res_valid, h.res_err, h.res_class);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        accept();
        run_layer(1, 3, 0);
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, h.req_ready, h.res_valid, fc2_start} !== 4'b0100 || fc1_shift !== 6'd7 || fc2_shift !== 6'd7) begin
            errors++;
            $display("FAIL mid_reset: got busy=%b rdy=%b vld=%b start=%b shifts=%0d/%0d want 0 1 0 0 7/7",
                     busy, h.req_ready, h.res_valid, fc2_start, fc1_shift, fc2_shift);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        accept();
        run_layer(1, 2, 0);
        run_layer(2, 2, 0);
        run_layer(3, 2, 4);
        checks++;
        if ({h.res_valid, h.res_err, h.res_class} !== 6'b1_0_0100) begin
            errors++;
            $display("FAIL post_reset_run: got vld=%b err=%b cls=%0d want 1 0 4", h.res_valid, h.res_err, h.res_class);
        end
        tick();
    endtask

    initial begin
        h.req_valid = 1'b0;
        h.res_ready = 1'b1;
        test_reset();
        test_normal();
        test_config();
        test_backpressure();
        test_spurious();
        test_watchdog();
        test_race();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
